vmsu_mul_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined signed/unsigned 8×8 Vedic multiplier (`vmsu_8bit_top`) among `NREQ` requesters. Each requester submits operands over a valid/ready handshake. The block issues at most one operation per cycle into the multiplier and tracks each operation's owner through the multiplier latency. Each result is parked in a per-requester slot until that requester accepts it.

---
 rtl/vmsu_pkg.sv | 15 +
 rtl/vmsu_mul_arbiter_chk.sv | 18 +
 rtl/vmsu_mul_arbiter_rr_arbiter.sv | 37 +++
 rtl/vmsu_mul_arbiter.sv | 136 +++++++++++++
 tb/tb_vmsu_mul_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vmsu_pkg.sv
// Shared widths, latency and index helpers for the Vedic multiplier scheduler.
package vmsu_pkg;

    localparam int MUL_LAT_DEFAULT = 2;
    localparam int OPND_W          = 8;
    localparam int PROD_W          = 16;

    typedef logic [OPND_W-1:0] opnd_t;
    typedef logic [PROD_W-1:0] prod_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vmsu_mul_arbiter_chk.sv
// Simulation-only invariants of the multiplier scheduler.
module vmsu_mul_arbiter_chk #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst,
    input logic [NREQ-1:0] i_grant,
    input logic [NREQ-1:0] i_retire,
    input logic [NREQ-1:0] i_consume
);

    a_no_retire_consume_clash: assert property (
        @(posedge clk) disable iff (rst) ((i_retire & i_consume) == {NREQ{1'b0}}));

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(i_grant));

endmodule

// File: rtl/vmsu_mul_arbiter_rr_arbiter.sv
// Combinational NREQ-way round-robin picker: searches upward from last+1 with wrap.
module rr_arbiter
    import vmsu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_gidx,
    output logic            o_gvalid
);

    logic [IW-1:0] w_cand;
    logic          w_found;

    // First eligible index after the previous winner takes the grant
    always_comb begin
        w_found = 1'b0;
        w_cand  = {IW{1'b0}};
        o_gidx  = {IW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(i_last) + k) % NREQ);
            if (!w_found && i_elig[w_cand]) begin
                w_found = 1'b1;
                o_gidx  = w_cand;
            end else begin
                w_found = w_found;
            end
        end
        o_grant         = {NREQ{1'b0}};
        o_grant[o_gidx] = w_found;
        o_gvalid        = w_found;
    end

endmodule

// File: rtl/vmsu_mul_arbiter.sv
// Shares one pipelined 8x8 signed/unsigned multiplier among NREQ requesters,
// tracking each operation's owner and parking results in per-requester slots.
module vmsu_mul_arbiter
    import vmsu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [OPND_W*NREQ-1:0] req_a,
    input  logic [OPND_W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]        req_signed,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [PROD_W*NREQ-1:0] rsp_p,
    output logic [OPND_W-1:0]      mul_a,
    output logic [OPND_W-1:0]      mul_b,
    output logic                   mul_control,
    input  logic [PROD_W-1:0]      mul_p,
    output logic                   busy
);

    localparam int IW = idx_width(NREQ);

    logic [IW-1:0]          r_last;
    logic [MUL_LAT-1:0]     r_pipe_v;
    logic [IW-1:0]          r_pipe_idx [MUL_LAT];
    logic [NREQ-1:0]        r_rsp_valid;
    logic [PROD_W*NREQ-1:0] r_rsp_p;

    logic [NREQ-1:0] w_inflight;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_retire;
    logic [NREQ-1:0] w_consume;
    logic [IW-1:0]   w_gidx;
    logic            w_gvalid;

    // Owners of operations still travelling through the multiplier
    always_comb begin
        w_inflight = {NREQ{1'b0}};
        for (int s = 0; s < MUL_LAT; s++) begin
            w_inflight[r_pipe_idx[s]] = w_inflight[r_pipe_idx[s]] | r_pipe_v[s];
        end
    end

    assign w_elig    = req_valid & ~w_inflight & ~r_rsp_valid & {NREQ{~rst}};
    assign w_consume = r_rsp_valid & rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .i_elig   (w_elig),
        .i_last   (r_last),
        .o_grant  (w_grant),
        .o_gidx   (w_gidx),
        .o_gvalid (w_gvalid)
    );

    assign req_ready = w_grant;

    // Grant is one-hot, so an AND-OR mux steers the winner onto the multiplier
    always_comb begin
        mul_a       = {OPND_W{1'b0}};
        mul_b       = {OPND_W{1'b0}};
        mul_control = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            mul_a       = mul_a | (req_a[OPND_W*i +: OPND_W] & {OPND_W{w_grant[i]}});
            mul_b       = mul_b | (req_b[OPND_W*i +: OPND_W] & {OPND_W{w_grant[i]}});
            mul_control = mul_control | (req_signed[i] & w_grant[i]);
        end
    end

    // One-hot slot select for the operation leaving the last stage
    always_comb begin
        w_retire                          = {NREQ{1'b0}};
        w_retire[r_pipe_idx[MUL_LAT-1]]   = r_pipe_v[MUL_LAT-1];
    end

    // Round-robin pointer and owner-tracking shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= IW'(NREQ - 1);
            r_pipe_v <= {MUL_LAT{1'b0}};
            for (int s = 0; s < MUL_LAT; s++) begin
                r_pipe_idx[s] <= {IW{1'b0}};
            end
        end else begin
            if (w_gvalid) begin
                r_last <= w_gidx;
            end
            r_pipe_v[0]   <= w_gvalid;
            r_pipe_idx[0] <= w_gidx;
            for (int s = 1; s < MUL_LAT; s++) begin
                r_pipe_v[s]   <= r_pipe_v[s-1];
                r_pipe_idx[s] <= r_pipe_idx[s-1];
            end
        end
    end

    // Result slots: retire fills, consume empties; data holds until overwritten
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= {NREQ{1'b0}};
            r_rsp_p     <= {(PROD_W*NREQ){1'b0}};
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_retire[i]) begin
                    r_rsp_valid[i]                <= 1'b1;
                    r_rsp_p[PROD_W*i +: PROD_W]   <= mul_p;
                end else if (w_consume[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_p     = r_rsp_p;
    assign busy      = (|r_pipe_v) | (|r_rsp_valid);

    vmsu_mul_arbiter_chk #(
        .NREQ (NREQ)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .i_grant   (w_grant),
        .i_retire  (w_retire),
        .i_consume (w_consume)
    );

endmodule

// File: tb/tb_vmsu_mul_arbiter.sv
// Scoreboard bench for vmsu_mul_arbiter with a two-stage multiplier stand-in.
module tb_vmsu_mul_arbiter;
    import vmsu_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    localparam int K_READY = 0;
    localparam int K_BUSY  = 1;
    localparam int K_RSPV  = 2;
    localparam int K_MUL   = 3;
    localparam int K_MULC  = 4;
    localparam int K_SLOT  = 5;
    localparam int K_DRAIN = 6;

    typedef struct {
        logic [15:0] p;
        int          due;
    } rsp_exp_t;

    typedef struct {
        int          kind;
        int          cyc;
        int          idx;
        logic [15:0] v;
    } probe_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready, req_signed, rsp_valid, rsp_ready;
    logic [8*NREQ-1:0]   req_a, req_b;
    logic [16*NREQ-1:0]  rsp_p;
    logic [7:0]          mul_a, mul_b;
    logic                mul_control;
    logic [15:0]         mul_p;
    logic                busy;

    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    rsp_exp_t rq [NREQ][$];
    probe_t   pq [$];
    logic [NREQ-1:0] hold;
    logic [15:0]     exp_p [NREQ];
    logic [NREQ-1:0] prev_v = '0;
    logic [NREQ-1:0] outstanding = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vmsu_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_control(mul_control),
        .mul_p(mul_p), .busy(busy)
    );

    // Multiplier stand-in: input flops then product flops, async active-low reset
    logic       mul_rst_n;
    logic [7:0] m_a, m_b;
    logic       m_c;
    assign mul_rst_n = ~rst;

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa, sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        if (s) return 16'(sa * sb);
        return {8'h00, a} * {8'h00, b};
    endfunction

    always @(posedge clk or negedge mul_rst_n) begin
        if (!mul_rst_n) begin
            m_a <= 8'h00; m_b <= 8'h00; m_c <= 1'b0; mul_p <= 16'h0000;
        end else begin
            m_a <= mul_a; m_b <= mul_b; m_c <= mul_control;
            mul_p <= prod(m_a, m_b, m_c);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: timed probes, response scoreboard, and a grant-ownership model
    always @(negedge clk) begin
        probe_t   pr;
        rsp_exp_t e;
        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            pr = pq.pop_front();
            chk("probe_cycle", pr.cyc, cyc);
            case (pr.kind)
                K_READY: chk("req_ready", req_ready, pr.v);
                K_BUSY:  chk("busy", busy, pr.v);
                K_RSPV:  chk("rsp_valid", rsp_valid, pr.v);
                K_MUL:   chk("mul_ab", {mul_a, mul_b}, pr.v);
                K_MULC:  chk("mul_control", mul_control, pr.v);
                K_SLOT:  chk("rsp_p_slot", rsp_p[16*pr.idx +: 16], pr.v);
                K_DRAIN: for (int i = 0; i < NREQ; i++) chk("pending_rsp", rq[i].size(), 0);
                default: chk("probe_kind", pr.kind, 0);
            endcase
        end
        if (rst) begin
            outstanding = '0;
            chk("ready_in_reset", req_ready, 0);
        end else begin
            chk("ready_onehot", $countones(req_ready) <= 1, 1'b1);
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && !prev_v[i]) begin
                    if (rq[i].size() == 0) begin
                        chk("rsp_unexpected", rsp_valid[i], 1'b0);
                    end else begin
                        e = rq[i].pop_front();
                        chk("rsp_p", rsp_p[16*i +: 16], e.p);
                        chk("rsp_latency", cyc, e.due);
                    end
                end
                if (req_ready[i]) begin
                    chk("grant_while_owned", outstanding[i], 1'b0);
                    outstanding[i] = 1'b1;
                end
                if (rsp_valid[i] && rsp_ready[i]) outstanding[i] = 1'b0;
            end
        end
        prev_v <= rsp_valid;
    end

    task automatic probe(input int kind, input int dly, input int idx, input logic [15:0] v);
        probe_t pr;
        pr.kind = kind; pr.cyc = cyc + dly; pr.idx = idx; pr.v = v;
        pq.push_back(pr);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] e);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_signed[i]   = s;
        exp_p[i]        = e;
        req_valid[i]    = 1'b1;
    endtask

    // One clock: record accepts into the scoreboard, then drop non-held requests
    task automatic step();
        logic [NREQ-1:0] acc;
        rsp_exp_t        e;
        @(negedge clk);
        acc = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                e.p = exp_p[i]; e.due = cyc + LAT + 1;
                rq[i].push_back(e);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) if (acc[i] && !hold[i]) req_valid[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_signed = '0;
        rsp_ready = '1; hold = '0;
        @(posedge clk); #1;

        // All four requesters valid while reset is still held
        set_req(0, 8'd200, 8'd100, 1'b0, 16'h4E20);
        set_req(1, 8'h03,  8'h05,  1'b0, 16'h000F);
        set_req(2, 8'hF6,  8'h07,  1'b1, 16'hFFBA);
        set_req(3, 8'h80,  8'h80,  1'b1, 16'h4000);
        probe(K_READY, 0, 0, 16'h0); probe(K_BUSY, 0, 0, 16'h0); probe(K_RSPV, 0, 0, 16'h0);
        probe(K_MUL, 0, 0, 16'h0); probe(K_SLOT, 0, 2, 16'h0);
        step();
        rst = 1'b0;
        probe(K_READY, 0, 0, 16'h1); probe(K_MUL, 0, 0, 16'hC864); probe(K_MULC, 0, 0, 16'h0);
        probe(K_READY, 1, 0, 16'h2); probe(K_BUSY, 1, 0, 16'h1);
        probe(K_READY, 2, 0, 16'h4); probe(K_MUL, 2, 0, 16'hF607); probe(K_MULC, 2, 0, 16'h1);
        probe(K_READY, 3, 0, 16'h8); probe(K_MUL, 3, 0, 16'h8080);
        probe(K_READY, 4, 0, 16'h0); probe(K_RSPV, 4, 0, 16'h2);
        probe(K_BUSY, 7, 0, 16'h0); probe(K_SLOT, 7, 0, 16'h4E20);
        probe(K_SLOT, 7, 2, 16'hFFBA); probe(K_SLOT, 7, 3, 16'h4000);
        repeat (8) step();

        // Backpressure: slot 1 held, requesters 0 and 2 keep streaming
        rsp_ready[1] = 1'b0; hold = 4'b0111;
        set_req(0, 8'h02, 8'h03, 1'b0, 16'h0006);
        set_req(1, 8'h10, 8'h10, 1'b0, 16'h0100);
        set_req(2, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        probe(K_READY, 0, 0, 16'h1); probe(K_READY, 1, 0, 16'h2); probe(K_READY, 2, 0, 16'h4);
        probe(K_READY, 3, 0, 16'h0); probe(K_READY, 4, 0, 16'h1);
        probe(K_READY, 5, 0, 16'h0); probe(K_RSPV, 5, 0, 16'h6);
        probe(K_READY, 6, 0, 16'h4); probe(K_READY, 8, 0, 16'h1);
        probe(K_RSPV, 9, 0, 16'h6); probe(K_SLOT, 9, 1, 16'h0100);
        repeat (10) step();

        // Release slot 1; it must be regranted once the slot clears
        hold = '0; req_valid[0] = 1'b0; req_valid[2] = 1'b0; rsp_ready[1] = 1'b1;
        probe(K_READY, 0, 0, 16'h0); probe(K_READY, 1, 0, 16'h2);
        repeat (8) step();

        // Reset one cycle after issue discards the in-flight operation
        probe(K_BUSY, 0, 0, 16'h0);
        set_req(3, 8'h11, 8'h11, 1'b0, 16'h0121);
        probe(K_READY, 0, 0, 16'h8);
        step();
        rst = 1'b1;
        rq[3].delete();
        set_req(0, 8'h07, 8'h06, 1'b0, 16'h002A);
        set_req(2, 8'h05, 8'h09, 1'b0, 16'h002D);
        probe(K_READY, 0, 0, 16'h0); probe(K_BUSY, 0, 0, 16'h1);
        probe(K_READY, 1, 0, 16'h1); probe(K_BUSY, 1, 0, 16'h0); probe(K_RSPV, 1, 0, 16'h0);
        probe(K_READY, 2, 0, 16'h4); probe(K_RSPV, 2, 0, 16'h0);
        probe(K_RSPV, 3, 0, 16'h0); probe(K_RSPV, 4, 0, 16'h1);
        probe(K_BUSY, 9, 0, 16'h0); probe(K_DRAIN, 9, 0, 16'h0);
        step();
        rst = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
